// File: rtl/hdmi_pll_pkg.sv
// Shared types and default timing for the HDMI pixel-PLL reset/lock sequencer.
package hdmi_pll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_seq_state_e;

    // 50 MHz reference: 16-cycle reset pulse, 1 ms lock window, ~20 us stability.
    localparam int unsigned DEF_RST_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES   = 3;
    localparam int unsigned DEF_SYNC_STAGES   = 2;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/prim_sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous level; all stages reset low.
module prim_sync_2ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hdmi_pll_seq.sv
// Reset/lock sequencer for the HDMI pixel-clock PLL, running on the 50 MHz reference clock.
module hdmi_pll_seq
    import hdmi_pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    localparam int unsigned RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            pll_locked_i,
    output logic            pll_rst_o,
    output logic            pll_ready_o,
    output logic            video_rst_no,
    output logic            lock_lost_o,
    output logic            fault_o,
    output logic [RC_W-1:0] retry_cnt_o
);

    localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    pll_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             ready_q, ready_d;
    logic             lost_q, lost_d;
    logic             fault_q, fault_d;
    logic             retry_req;
    logic             lock_s;

    prim_sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_locked_i),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        lost_d    = 1'b0;
        retry_req = 1'b0;

        if (!enable_i) begin
            state_d = IDLE;
            retry_d = '0;
        end else begin
            unique case (state_q)
                IDLE:      state_d = RESET;
                RESET:     if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_req = 1'b1;
                    end
                end
                STABLE: begin
                    // A drop on the completion cycle still counts as a failed attempt.
                    if (!lock_s) begin
                        retry_req = 1'b1;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        lost_d  = 1'b1;
                        retry_d = RC_W'(1);
                        state_d = RESET;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end

        if (retry_req) begin
            if (retry_q == RC_W'(MAX_RETRIES)) begin
                state_d = FAULT;
            end else begin
                retry_d = retry_q + RC_W'(1);
                state_d = RESET;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {RESET, WAIT_LOCK, STABLE}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        pll_rst_d = (state_d inside {IDLE, RESET, FAULT});
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            lost_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign pll_ready_o  = ready_q;
    assign video_rst_no = ready_q;
    assign lock_lost_o  = lost_q;
    assign fault_o      = fault_q;
    assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_hdmi_pll_seq.sv
// Self-checking bench for hdmi_pll_seq: deadline-based reference model plus directed and random scenarios.
module tb_hdmi_pll_seq;

    localparam int RST = 16;
    localparam int LT  = 200;
    localparam int SC  = 1024;
    localparam int MR  = 3;
    localparam int SS  = 2;

    localparam int PH_IDLE = 0, PH_RST = 1, PH_WAIT = 2, PH_STAB = 3, PH_RUN = 4, PH_FLT = 5;

    logic       clk = 1'b0;
    logic       rst_n, enable, locked;
    logic       pll_rst_o, pll_ready_o, video_rst_no, lock_lost_o, fault_o;
    logic [1:0] retry_cnt_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int m_ph, m_end, m_retry;
    bit m_lost;
    bit lq[$];

    hdmi_pll_seq #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .pll_locked_i (locked),
        .pll_rst_o    (pll_rst_o),
        .pll_ready_o  (pll_ready_o),
        .video_rst_no (video_rst_no),
        .lock_lost_o  (lock_lost_o),
        .fault_o      (fault_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        m_ph = PH_IDLE; m_retry = 0; m_lost = 0; m_end = 0;
        lq.delete();
        for (int i = 0; i < SS; i++) lq.push_back(1'b0);
    endtask

    task automatic model_enter_reset();
        m_ph  = PH_RST;
        m_end = cyc + RST;
    endtask

    task automatic model_fail();
        if (m_retry == MR) m_ph = PH_FLT;
        else begin m_retry++; model_enter_reset(); end
    endtask

    // Each phase ends at an absolute edge number; lock is the raw input delayed SS edges.
    task automatic model_step(input bit en, input bit lk);
        bit ls;
        ls = lq.pop_front();
        lq.push_back(lk);
        m_lost = 1'b0;
        if (!en) begin
            m_ph = PH_IDLE; m_retry = 0;
        end else begin
            case (m_ph)
                PH_IDLE: model_enter_reset();
                PH_RST:  if (cyc == m_end) begin m_ph = PH_WAIT; m_end = cyc + LT; end
                PH_WAIT: begin
                    if (ls) begin m_ph = PH_STAB; m_end = cyc + SC; end
                    else if (cyc == m_end) model_fail();
                end
                PH_STAB: begin
                    if (!ls) model_fail();
                    else if (cyc == m_end) begin m_ph = PH_RUN; m_retry = 0; end
                end
                PH_RUN:  if (!ls) begin m_lost = 1'b1; m_retry = 1; model_enter_reset(); end
                default: ;
            endcase
        end
    endtask

    always begin
        logic [6:0] got, exp;
        @(posedge clk);
        cyc++;
        if (!rst_n) model_reset();
        else model_step(enable, locked);
        #1;
        exp = {m_ph == PH_IDLE || m_ph == PH_RST || m_ph == PH_FLT, m_ph == PH_RUN,
               m_ph == PH_RUN, m_lost, m_ph == PH_FLT, 2'(m_retry)};
        got = {pll_rst_o, pll_ready_o, video_rst_no, lock_lost_o, fault_o, retry_cnt_o};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL model_cmp cyc=%0d got(rst,rdy,vrst,lost,flt,rc)=%b exp=%b", cyc, got, exp);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic outsel(input int w);
        case (w)
            0:       return pll_rst_o;
            1:       return pll_ready_o;
            2:       return lock_lost_o;
            default: return fault_o;
        endcase
    endfunction

    task automatic wait_out(input string name, input int w, input logic val, input int budget,
                            output int edge_no);
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (outsel(w) === val) begin edge_no = cyc; break; end
        end
        if (edge_no < 0) begin
            tests++; fails++;
            $display("FAIL %s timeout after %0d cycles", name, budget);
        end
    endtask

    // Enable from IDLE, lock 100 cycles after the PLL reset falls, expect RUN.
    task automatic bringup_normal(input string tag);
        int e_en, e_fall, e_samp, e_rdy;
        locked = 1'b0;
        enable = 1'b1;
        e_en = cyc + 1;
        wait_out({tag, "_rst_fall"}, 0, 1'b0, 100, e_fall);
        check({tag, "_rst_width"}, e_fall - e_en, RST);
        step(99);
        locked = 1'b1;
        e_samp = cyc + 1;
        wait_out({tag, "_ready"}, 1, 1'b1, 1200, e_rdy);
        // Sampling edge counts as the first of SS+SC+1 edges.
        check({tag, "_lock_latency"}, e_rdy - e_samp, SS + SC);
        check({tag, "_vrst"}, video_rst_no, 1);
        check({tag, "_retry"}, retry_cnt_o, 0);
    endtask

    initial begin
        int e, falls;
        logic prev;
        int seen[4];
        rst_n = 1'b1; enable = 1'b0; locked = 1'b0;
        #1 rst_n = 1'b0;
        step(3);
        check("rst_pll_rst", pll_rst_o, 1);
        check("rst_ready", pll_ready_o, 0);
        check("rst_vrst", video_rst_no, 0);
        check("rst_lost", lock_lost_o, 0);
        check("rst_fault", fault_o, 0);
        check("rst_retry", retry_cnt_o, 0);
        rst_n = 1'b1;
        step(2);

        bringup_normal("normal");

        // Never lock: four attempts, then sticky fault.
        enable = 1'b0; locked = 1'b0;
        step(3);
        enable = 1'b1;
        falls = 0; prev = pll_rst_o;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (prev && !pll_rst_o) begin
                if (falls < 4) seen[falls] = retry_cnt_o;
                falls++;
            end
            prev = pll_rst_o;
            if (fault_o) break;
        end
        check("nolock_attempts", falls, 4);
        for (int i = 0; i < 4; i++) check("nolock_retry_seq", seen[i], i);
        check("nolock_fault", fault_o, 1);
        check("nolock_fault_rst", pll_rst_o, 1);
        step(50);
        check("nolock_fault_sticky", fault_o, 1);
        enable = 1'b0;
        step(1);
        check("nolock_dis_fault", fault_o, 0);
        check("nolock_dis_retry", retry_cnt_o, 0);
        check("nolock_dis_rst", pll_rst_o, 1);

        // Glitch while STABLE.
        enable = 1'b1;
        wait_out("glitch_rst_fall", 0, 1'b0, 100, e);
        step(10);
        locked = 1'b1;
        step(502);
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        wait_out("glitch_rst_rise", 0, 1'b1, 20, e);
        check("glitch_retry", retry_cnt_o, 1);
        wait_out("glitch_ready", 1, 1'b1, 1200, e);
        check("glitch_retry_clr", retry_cnt_o, 0);

        // Lock loss in RUN.
        locked = 1'b0;
        wait_out("loss_pulse", 2, 1'b1, 10, e);
        check("loss_ready", pll_ready_o, 0);
        check("loss_vrst", video_rst_no, 0);
        check("loss_pll_rst", pll_rst_o, 1);
        check("loss_retry", retry_cnt_o, 1);
        step(1);
        check("loss_pulse_width", lock_lost_o, 0);
        locked = 1'b1;
        begin
            int e_fall;
            wait_out("loss_rst_fall", 0, 1'b0, 40, e_fall);
            check("loss_rst_width", e_fall - e, RST);
        end
        wait_out("loss_relock", 1, 1'b1, 1200, e);

        // Disable mid-RUN, then mid-WAIT_LOCK.
        enable = 1'b0;
        step(1);
        check("dis_run_rst", pll_rst_o, 1);
        check("dis_run_ready", pll_ready_o, 0);
        locked = 1'b0;
        enable = 1'b1;
        wait_out("dis_wait_fall", 0, 1'b0, 100, e);
        step(20);
        enable = 1'b0;
        step(1);
        check("dis_wait_rst", pll_rst_o, 1);
        check("dis_wait_retry", retry_cnt_o, 0);
        step(2);
        bringup_normal("reenable");

        // Asynchronous reset between edges while in RUN.
        #5 rst_n = 1'b0;
        #1;
        check("arst_pll_rst", pll_rst_o, 1);
        check("arst_ready", pll_ready_o, 0);
        check("arst_vrst", video_rst_no, 0);
        check("arst_fault", fault_o, 0);
        check("arst_retry", retry_cnt_o, 0);
        step(2);
        rst_n = 1'b1;
        bringup_normal("post_arst");

        // Randomized enable/lock activity, checked by the model every cycle.
        for (int s = 0; s < 24; s++) begin
            locked = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) step($urandom_range(1, 8));
            else step($urandom_range(50, 600));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
